sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM. It accepts one 32-bit read or write per request from the MEM stage and performs it as two 16-bit half-word accesses, low half first. While an access is in flight it holds `ready` low so the pipeline freezes. It replaces the single-cycle data memory behind `MEM_Stage` and is clocked with the core.

## Interface
Reset is asynchronous and active-high.

Parameters:
- `PHASE_CYCLES`, default 2: cycles per half-word access. Legal values are ≥ 2.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.

Ports (clock and reset first):
- `clk` input 1: core clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wr_en` input 1: MEM-stage write request. Held stable while `ready` = 0.
- `rd_en` input 1: MEM-stage read request. Held stable while `ready` = 0.
- `address` input 32: byte address from the ALU result.
- `writeData` input 32: store data.
- `readData` output 32: load data, registered.
- `ready` output 1: 1 means the pipeline may advance. 0 means freeze.
- `sram_addr` output 18: SRAM half-word address.
- `sram_dq_o` output 16: write data to the SRAM pads.
- `sram_dq_i` input 16: read data from the SRAM pads.
- `sram_dq_oe` output 1: pad output enable, 1 = drive.
- `sram_we_n` output 1: SRAM write strobe, active low.
- `sram_oe_n` output 1: SRAM output enable, active low.

## Operation

FSM states: IDLE, LOW, HIGH, DONE. A phase counter `cnt` counts 0..PHASE_CYCLES-1.

Accept and latch:
- In IDLE with `wr_en` | `rd_en`, latch the request on the clock edge, then go to LOW with `cnt` = 0.
- Latched fields: op (write if `wr_en`, else read), `eff = address - BASE_ADDR` truncated to 32 bits, and `writeData`.
- `wr_en` has priority when both enables are high.

Address mapping:
- `sram_addr = {eff[18:2], half}`, with half = 0 in LOW and 1 in HIGH.
- `address[1:0]` is ignored. Addresses that wrap below `BASE_ADDR` alias modulo 2^19.

LOW phase:
- Lasts PHASE_CYCLES cycles.
- On `cnt` = PHASE_CYCLES-1, go to HIGH with `cnt` = 0.

HIGH phase:
- Same length as LOW.
- On `cnt` = PHASE_CYCLES-1, go to DONE.

DONE:
- Lasts 1 cycle, then returns to IDLE unconditionally.

Read phase:
- `sram_oe_n` = 0, `sram_we_n` = 1, `sram_dq_oe` = 0.
- On the last cycle of LOW, capture `sram_dq_i` into `readData[15:0]`.
- On the last cycle of HIGH, capture `sram_dq_i` into `readData[31:16]`.

Write phase:
- `sram_dq_oe` = 1 for the whole phase. `sram_dq_o` = wdata[15:0] in LOW, wdata[31:16] in HIGH.
- `sram_we_n` = 0 for `cnt` < PHASE_CYCLES-1, and 1 on the last cycle of the phase. Address and data are therefore stable across the rising edge of `sram_we_n`.
- `sram_oe_n` = 1.

`readData`:
- Changes only on read captures.
- Holds its value through writes and idle cycles.
- Is not updated by a write.

`ready` (combinational):
- 0 when (IDLE and (`wr_en` | `rd_en`)) or state is LOW or HIGH.
- 1 in DONE, and in IDLE with no request.

Outside active phases (IDLE and DONE):
- `sram_we_n` = 1, `sram_oe_n` = 1, `sram_dq_oe` = 0.
- `sram_addr` holds its last value.

## Timing

Request latency:
- A request is first seen in cycle t0.
- `ready` is 0 for cycles t0 .. t0+2·PHASE_CYCLES.
- `ready` is 1 in DONE at t0+2·PHASE_CYCLES+1.
- Total is 2·PHASE_CYCLES+2 cycles per access. With the default, `ready` is 0 for 5 cycles, then 1 for 1.

Read data:
- `readData` holds the full word in DONE and afterwards.
- The pipeline samples it on the DONE edge.

Back-to-back requests:
- A new request can appear on the cycle after DONE, in IDLE. It is accepted with no gap beyond the DONE cycle.

Stability:
- Request inputs may change during LOW or HIGH without effect, because everything used is latched.

Reset (asynchronous, may occur mid-operation):
- State returns to IDLE immediately, `cnt` = 0.
- `readData` = 0, `sram_addr` = 0, `sram_dq_o` = 0.
- `sram_we_n` = 1, `sram_oe_n` = 1, `sram_dq_oe` = 0.
- Any partial write is abandoned, and the SRAM contents for that word are undefined.
- `ready` follows its combinational rule: 1 unless a request is present.

## Test plan

1. Reset, then idle with no request: `ready` = 1, `sram_we_n` = `sram_oe_n` = 1, `sram_dq_oe` = 0, `readData` = 0.
2. Write: `wr_en` = 1, `address` = 1024+8, `writeData` = 0xDEADBEEF.
   - `ready` is 0 for 5 cycles.
   - `sram_addr` = 4 with `sram_dq_o` = 0xBEEF, then `sram_addr` = 5 with `sram_dq_o` = 0xDEAD.
   - `sram_we_n` pulses low for 1 cycle in each phase.
3. Read: `rd_en` = 1 at `address` 1032, SRAM model returns 0xBEEF at address 4 and 0xDEAD at address 5.
   - In DONE, `readData` = 0xDEADBEEF and `ready` = 1.
   - `readData` stays 0xDEADBEEF through 3 following idle cycles.
4. `wr_en` and `rd_en` both high at `address` 1028 with `writeData` 0x12345678: a write occurs to `sram_addr` 2 and 3, and `readData` is unchanged.
5. Back-to-back: a write, then a read issued in the cycle after DONE. The second access starts with no extra idle cycle and `ready` is 0 for 5 cycles again. Repeat with `PHASE_CYCLES` = 3: `ready` is 0 for 7 cycles.
6. Assert `rst` during HIGH of a write: in the same cycle `sram_we_n` = 1, `sram_dq_oe` = 0 and state = IDLE. After `rst` is released, the next read completes normally.

Source files
------------

// File: rtl/sram_controller.sv
// Bridges the MEM stage to a 16-bit asynchronous SRAM. Each 32-bit request
// becomes two half-word accesses (low then high) while ready holds the pipeline.
module sram_controller #(
    parameter int PHASE_CYCLES = 2,
    parameter int BASE_ADDR    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);
    localparam int CNT_W = $clog2(PHASE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [16:0]      word_q, word_d;
    logic [15:0]      wdata_hi_q, wdata_hi_d;
    logic [31:0]      read_data_q, read_data_d;
    logic [17:0]      sram_addr_q, sram_addr_d;
    logic [15:0]      dq_o_q, dq_o_d;

    logic [31:0] eff;
    logic        last;
    logic        active;
    logic        unused_eff_bits;

    assign eff             = address - 32'(BASE_ADDR);
    assign unused_eff_bits = ^{eff[31:19], eff[1:0]};
    assign last            = (cnt_q == LAST);
    assign active          = (state_q == LOW) || (state_q == HIGH);

    // Address and pad data are registered on phase entry so they are already
    // stable in the first cycle of each phase and hold through IDLE/DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        word_d      = word_q;
        wdata_hi_d  = wdata_hi_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    state_d     = LOW;
                    cnt_d       = '0;
                    op_wr_d     = wr_en;
                    word_d      = eff[18:2];
                    wdata_hi_d  = writeData[31:16];
                    sram_addr_d = {eff[18:2], 1'b0};
                    dq_o_d      = writeData[15:0];
                end
            end
            LOW: begin
                if (last) begin
                    if (!op_wr_q) read_data_d[15:0] = sram_dq_i;
                    state_d     = HIGH;
                    cnt_d       = '0;
                    sram_addr_d = {word_q, 1'b1};
                    dq_o_d      = wdata_hi_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (last) begin
                    if (!op_wr_q) read_data_d[31:16] = sram_dq_i;
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            wdata_hi_q  <= wdata_hi_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
        end
    end

    // we_n releases on the final phase cycle so the write commits on its rising edge
    // while address and data are still driven.
    assign sram_dq_oe = active && op_wr_q;
    assign sram_we_n  = !(active && op_wr_q && !last);
    assign sram_oe_n  = !(active && !op_wr_q);
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign readData   = read_data_q;
    assign ready      = !(((state_q == IDLE) && (wr_en || rd_en)) || active);
endmodule

// File: tb/tb_sram_controller.sv
// Scoreboarded bench for sram_controller: two instances (PHASE_CYCLES 2 and 3),
// each with a behavioural SRAM that commits on the rising edge of we_n.
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en = 0, rd_en = 0;
    logic [31:0] address = 0, writeData = 0;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    logic        wr3 = 0, rd3 = 0;
    logic [31:0] addr3 = 0, wdata3 = 0;
    logic [31:0] rdata3;
    logic        ready3;
    logic [17:0] saddr3;
    logic [15:0] dqo3, dqi3;
    logic        dqoe3, we3_n, oe3_n;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_controller #(.PHASE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3), .address(addr3),
        .writeData(wdata3), .readData(rdata3), .ready(ready3),
        .sram_addr(saddr3), .sram_dq_o(dqo3), .sram_dq_i(dqi3),
        .sram_dq_oe(dqoe3), .sram_we_n(we3_n), .sram_oe_n(oe3_n)
    );

    logic [15:0] mem  [0:63];
    logic [15:0] mem3 [0:63];
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]  = 16'h0;
            mem3[i] = 16'h0;
        end
    end
    assign sram_dq_i = mem[sram_addr[5:0]];
    assign dqi3      = mem3[saddr3[5:0]];
    always @(posedge sram_we_n) if (!rst) mem[sram_addr[5:0]] <= sram_dq_o;
    always @(posedge we3_n) if (!rst) mem3[saddr3[5:0]] <= dqo3;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] exp_q [$];

    int               last_lo, last_we, start_cyc, done_cyc;
    logic [1:0][17:0] last_wa;
    logic [1:0][15:0] last_wd;

    task automatic do_access(input bit sel, input logic w, input logic r,
                             input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e;
        logic [31:0] exp_v;
        int   key;
        bit   done;
        logic rdy, wen;
        logic [17:0] sa;
        logic [15:0] sd;
        e   = a - 32'd1024;
        key = int'(e[18:2]) + (sel ? 200000 : 0);
        if (w) ref_mem[key] = d;
        else if (r) exp_q.push_back(ref_mem.exists(key) ? ref_mem[key] : 32'h0);
        @(posedge clk); #1;
        if (sel) begin wr3 = w; rd3 = r; addr3 = a; wdata3 = d; end
        else begin wr_en = w; rd_en = r; address = a; writeData = d; end
        last_lo = 0; last_we = 0; last_wa = '0; last_wd = '0; done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            rdy = sel ? ready3 : ready;
            wen = sel ? we3_n : sram_we_n;
            sa  = sel ? saddr3 : sram_addr;
            sd  = sel ? dqo3 : sram_dq_o;
            if (rdy) done = 1;
            else begin
                last_lo++;
                if (!wen) begin
                    last_we++;
                    last_wa[sa[0]] = sa;
                    last_wd[sa[0]] = sd;
                end
            end
        end
        done_cyc = cyc;
        if (sel) begin wr3 = 0; rd3 = 0; end
        else begin wr_en = 0; rd_en = 0; end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL access_timeout sel=%0d addr=%0d: ready never returned", sel, a);
        end
        if (!w && r) begin
            exp_v = exp_q.pop_front();
            checks++;
            if ((sel ? rdata3 : readData) !== exp_v) begin
                failures++;
                $display("FAIL read_data sel=%0d addr=%0d: got %h expected %h",
                         sel, a, sel ? rdata3 : readData, exp_v);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 ||
            sram_dq_oe !== 1'b0 || readData !== 32'h0 || sram_addr !== 18'h0) begin
            failures++;
            $display("FAIL reset_idle: ready=%b we_n=%b oe_n=%b oe=%b rd=%h addr=%h expected 1 1 1 0 0 0",
                     ready, sram_we_n, sram_oe_n, sram_dq_oe, readData, sram_addr);
        end
    endtask

    task automatic check_write(input string nm, input int lo, input int we,
                               input logic [17:0] a0, input logic [15:0] d0,
                               input logic [15:0] d1);
        checks++;
        if (last_lo !== lo || last_we !== we) begin
            failures++;
            $display("FAIL %s_timing: ready_low=%0d we_low=%0d expected %0d %0d",
                     nm, last_lo, last_we, lo, we);
        end
        checks++;
        if (last_wa[0] !== a0 || last_wd[0] !== d0 || last_wa[1] !== a0 + 18'd1 ||
            last_wd[1] !== d1) begin
            failures++;
            $display("FAIL %s_halves: lo %0d/%h hi %0d/%h expected %0d/%h %0d/%h", nm,
                     last_wa[0], last_wd[0], last_wa[1], last_wd[1], a0, d0, a0 + 18'd1, d1);
        end
    endtask

    task automatic test_write;
        do_access(0, 1, 0, 32'd1032, 32'hDEADBEEF);
        check_write("write", 5, 2, 18'd4, 16'hBEEF, 16'hDEAD);
    endtask

    task automatic test_read;
        do_access(0, 0, 1, 32'd1032, 32'h0);
        checks++;
        if (last_lo !== 5 || last_we !== 0) begin
            failures++;
            $display("FAIL read_timing: ready_low=%0d we_low=%0d expected 5 0", last_lo, last_we);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (readData !== 32'hDEADBEEF || ready !== 1'b1) begin
                failures++;
                $display("FAIL read_hold%0d: rd=%h ready=%b expected deadbeef 1", i, readData, ready);
            end
        end
    endtask

    task automatic test_both_enables;
        do_access(0, 1, 1, 32'd1028, 32'h12345678);
        check_write("both", 5, 2, 18'd2, 16'h5678, 16'h1234);
        checks++;
        if (readData !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL both_readdata_held: got %h expected deadbeef", readData);
        end
        do_access(0, 0, 1, 32'd1028, 32'h0);
    endtask

    task automatic test_back_to_back;
        int prev_done;
        do_access(0, 1, 0, 32'd1036, 32'hCAFEF00D);
        prev_done = done_cyc;
        do_access(0, 0, 1, 32'd1036, 32'h0);
        checks++;
        if (start_cyc - prev_done !== 1 || last_lo !== 5) begin
            failures++;
            $display("FAIL b2b_pc2: gap=%0d ready_low=%0d expected 1 5", start_cyc - prev_done, last_lo);
        end
        do_access(1, 1, 0, 32'd1040, 32'hA5A50F0F);
        check_write("pc3_write", 7, 4, 18'd8, 16'h0F0F, 16'hA5A5);
        prev_done = done_cyc;
        do_access(1, 0, 1, 32'd1040, 32'h0);
        checks++;
        if (start_cyc - prev_done !== 1 || last_lo !== 7) begin
            failures++;
            $display("FAIL b2b_pc3: gap=%0d ready_low=%0d expected 1 7", start_cyc - prev_done, last_lo);
        end
    endtask

    task automatic test_reset_mid_write;
        @(posedge clk); #1;
        wr_en = 1; address = 32'd1048; writeData = 32'h55AA55AA;
        repeat (4) @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== 18'd13) begin
            failures++;
            $display("FAIL mid_high_strobe: we_n=%b addr=%0d expected 0 13", sram_we_n, sram_addr);
        end
        rst = 1'b1; wr_en = 0;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_oe_n !== 1'b1 || ready !== 1'b1 ||
            readData !== 32'h0 || sram_addr !== 18'h0 || sram_dq_o !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: we_n=%b oe=%b oe_n=%b ready=%b rd=%h addr=%h dq=%h expected 1 0 1 1 0 0 0",
                     sram_we_n, sram_dq_oe, sram_oe_n, ready, readData, sram_addr, sram_dq_o);
        end
        @(posedge clk); #1 rst = 1'b0;
        do_access(0, 0, 1, 32'd1032, 32'h0);
        checks++;
        if (last_lo !== 5) begin
            failures++;
            $display("FAIL post_reset_read_timing: ready_low=%0d expected 5", last_lo);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_both_enables;
        test_back_to_back;
        test_reset_mid_write;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
